// File: rtl/alu_sequencer.sv
// alu_sequencer: sequences single-issue 8-bit ALU instructions over an
// 8-entry register file.
//
// Each instruction is accepted in IDLE. At the accept edge the operands and
// the ALU function are registered. The sequencer then waits ALU_WAIT cycles
// in EXEC and spends one cycle in WB. The ALU result is written to R[RD] at
// the edge that ends WB.
//
// state | meaning
// ------+------------------------------------------------------------------
// IDLE  | ready for an instruction; operand outputs hold their last values
// EXEC  | external ALU settling; wait_cnt counts down to zero
// WB    | DONE (and ERROR if the opcode is illegal); write-back at exit edge
module alu_sequencer #(
    parameter int ALU_WAIT = 1
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] INSTR,
    input  logic        INSTR_VALID,
    output logic        INSTR_READY,
    output logic [7:0]  ALU_DATA1,
    output logic [7:0]  ALU_DATA2,
    output logic [2:0]  ALU_SELECT,
    input  logic [7:0]  ALU_RESULT,
    output logic        DONE,
    output logic        ERROR,
    input  logic [2:0]  DBG_ADDR,
    output logic [7:0]  DBG_DATA
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_LOAD = 4'(ALU_WAIT - 1);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  wait_cnt;
    logic [2:0]  rd_q;
    logic        illegal_q;
    logic [7:0]  regs [8];

    logic        accept;
    logic [7:0]  op;
    logic [7:0]  rt_val;
    logic [7:0]  rs_val;
    logic [7:0]  imm;
    logic [7:0]  dec_data1;
    logic [7:0]  dec_data2;
    logic [2:0]  dec_select;
    logic        dec_illegal;

    // Bits of the instruction word that carry no field.
    logic        unused_instr_bits;
    assign unused_instr_bits = ^{INSTR[23:19], INSTR[15:11]};

    assign accept = INSTR_VALID && (state == IDLE);
    assign op     = INSTR[31:24];
    assign rt_val = regs[INSTR[10:8]];
    assign rs_val = regs[INSTR[2:0]];
    assign imm    = INSTR[7:0];

    // Decode the presented instruction into ALU operands and function select.
    always_comb begin
        dec_data1   = rt_val;
        dec_data2   = 8'h00;
        dec_select  = 3'b000;
        dec_illegal = 1'b0;
        case (op)
            8'h00: dec_data2 = imm;
            8'h01: dec_data2 = rs_val;
            8'h02: begin
                dec_select = 3'b001;
                dec_data2  = rs_val;
            end
            8'h03: begin
                dec_select = 3'b001;
                dec_data2  = 8'h00 - rs_val;
            end
            8'h04: begin
                dec_select = 3'b010;
                dec_data2  = rs_val;
            end
            8'h05: begin
                dec_select = 3'b011;
                dec_data2  = rs_val;
            end
            default: begin
                dec_illegal = 1'b1;
                dec_data1   = 8'h00;
            end
        endcase
    end

    // Next-state logic for the IDLE -> EXEC -> WB -> IDLE cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (INSTR_VALID) state_nxt = EXEC;
            EXEC: if (wait_cnt == 4'd0) state_nxt = WB;
            WB:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state <= IDLE;
        else       state <= state_nxt;
    end

    // EXEC down-counter; zero marks the last settling cycle.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wait_cnt <= 4'd0;
        end else if (accept) begin
            wait_cnt <= WAIT_LOAD;
        end else if (state == EXEC && wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
        end
    end

    // Capture operands, function and destination at the accept edge. These
    // values are held until the next accept.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ALU_DATA1  <= 8'h00;
            ALU_DATA2  <= 8'h00;
            ALU_SELECT <= 3'b000;
            rd_q       <= 3'd0;
            illegal_q  <= 1'b0;
        end else if (accept) begin
            ALU_DATA1  <= dec_data1;
            ALU_DATA2  <= dec_data2;
            ALU_SELECT <= dec_select;
            rd_q       <= INSTR[18:16];
            illegal_q  <= dec_illegal;
        end
    end

    // Register file write-back at the edge that leaves WB.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < 8; i++) regs[i] <= 8'h00;
        end else if (state == WB && !illegal_q) begin
            regs[rd_q] <= ALU_RESULT;
        end
    end

    assign INSTR_READY = (state == IDLE);
    assign DONE        = (state == WB);
    assign ERROR       = (state == WB) && illegal_q;
    assign DBG_DATA    = regs[DBG_ADDR];

endmodule

// File: tb/tb_alu_sequencer.sv
// Testbench for alu_sequencer. Two instances are used: one with ALU_WAIT=1
// for the directed and random single-issue runs, and one with ALU_WAIT=3
// driven with INSTR_VALID held high.
`timescale 1ns/1ps
module tb_alu_sequencer;

    localparam int W_A = 1;
    localparam int W_B = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr_a, instr_b;
    logic        valid_a, valid_b;
    logic        ready_a, ready_b;
    logic [7:0]  d1_a, d2_a, d1_b, d2_b;
    logic [2:0]  sel_a, sel_b;
    logic [7:0]  res_a, res_b;
    logic        done_a, done_b, err_a, err_b;
    logic [2:0]  dbg_addr_a, dbg_addr_b;
    logic [7:0]  dbg_a, dbg_b;

    int          tests = 0;
    int          fails = 0;
    logic [7:0]  ma [8];
    logic [7:0]  mb [8];

    always #20 clk = ~clk;

    alu_sequencer #(.ALU_WAIT(W_A)) dut_a (
        .CLK(clk), .RESET(rst), .INSTR(instr_a), .INSTR_VALID(valid_a),
        .INSTR_READY(ready_a), .ALU_DATA1(d1_a), .ALU_DATA2(d2_a),
        .ALU_SELECT(sel_a), .ALU_RESULT(res_a), .DONE(done_a), .ERROR(err_a),
        .DBG_ADDR(dbg_addr_a), .DBG_DATA(dbg_a)
    );

    alu_sequencer #(.ALU_WAIT(W_B)) dut_b (
        .CLK(clk), .RESET(rst), .INSTR(instr_b), .INSTR_VALID(valid_b),
        .INSTR_READY(ready_b), .ALU_DATA1(d1_b), .ALU_DATA2(d2_b),
        .ALU_SELECT(sel_b), .ALU_RESULT(res_b), .DONE(done_b), .ERROR(err_b),
        .DBG_ADDR(dbg_addr_b), .DBG_DATA(dbg_b)
    );

    // External combinational ALU.
    function automatic logic [7:0] alu(input logic [2:0] s, input logic [7:0] a, input logic [7:0] b);
        case (s)
            3'b000:  return b;
            3'b001:  return a + b;
            3'b010:  return a & b;
            3'b011:  return a | b;
            default: return 8'h00;
        endcase
    endfunction

    assign res_a = alu(sel_a, d1_a, d2_a);
    assign res_b = alu(sel_b, d1_b, d2_b);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk(input logic [7:0] op, input logic [2:0] rd,
                                       input logic [2:0] rt, input logic [7:0] imm);
        return {op, 5'b0, rd, 5'b0, rt, imm};
    endfunction

    // Reference model: the architectural effect of one instruction, computed
    // with plain integer arithmetic.
    function automatic void ref_op(input logic [31:0] ins, input logic [7:0] r [8],
                                   output logic [7:0] e1, output logic [7:0] e2,
                                   output logic [2:0] es, output logic [7:0] er,
                                   output logic ill);
        int rt, rs, imm;
        rt  = int'(r[ins[10:8]]);
        rs  = int'(r[ins[2:0]]);
        imm = int'(ins[7:0]);
        e1  = 8'(rt);
        e2  = 8'h00;
        es  = 3'd0;
        er  = 8'h00;
        ill = 1'b0;
        case (ins[31:24])
            8'h00: begin e2 = 8'(imm); er = 8'(imm); end
            8'h01: begin e2 = 8'(rs); er = 8'(rs); end
            8'h02: begin es = 3'd1; e2 = 8'(rs); er = 8'((rt + rs) % 256); end
            8'h03: begin es = 3'd1; e2 = 8'((256 - rs) % 256); er = 8'((rt - rs + 256) % 256); end
            8'h04: begin es = 3'd2; e2 = 8'(rs); er = 8'(rt) & 8'(rs); end
            8'h05: begin es = 3'd3; e2 = 8'(rs); er = 8'(rt) | 8'(rs); end
            default: begin ill = 1'b1; e1 = 8'h00; end
        endcase
    endfunction

    // Issue one instruction to dut_a. The task is entered just after a
    // falling edge and returns just after the falling edge that follows
    // write-back, so back-to-back calls issue at the minimum interval.
    task automatic run_a(input logic [31:0] ins);
        logic [7:0] e1, e2, er;
        logic [2:0] es;
        logic       ill;
        int         lat;
        ref_op(ins, ma, e1, e2, es, er, ill);
        instr_a = ins;
        valid_a = 1'b1;
        check("ready_idle", 32'(ready_a), 32'(1));
        @(posedge clk);
        @(negedge clk);
        valid_a = 1'b0;
        instr_a = $urandom;
        check("ready_busy", 32'(ready_a), 32'(0));
        check("data1", 32'(d1_a), 32'(e1));
        check("data2", 32'(d2_a), 32'(e2));
        check("select", 32'(sel_a), 32'(es));
        lat = 1;
        while (!done_a && lat <= 20) begin
            @(negedge clk);
            lat++;
        end
        check("latency", 32'(lat), 32'(W_A + 1));
        check("error", 32'(err_a), 32'(ill));
        check("data2_hold", 32'(d2_a), 32'(e2));
        check("select_hold", 32'(sel_a), 32'(es));
        @(negedge clk);
        check("done_pulse", 32'(done_a), 32'(0));
        check("ready_back", 32'(ready_a), 32'(1));
        if (!ill) ma[ins[18:16]] = er;
        dbg_addr_a = ins[18:16];
        #1;
        check("dbg_rd", 32'(dbg_a), 32'(ma[ins[18:16]]));
    endtask

    task automatic sweep_a();
        for (int i = 0; i < 8; i++) begin
            dbg_addr_a = 3'(i);
            #1;
            check("reg_a", 32'(dbg_a), 32'(ma[i]));
        end
    endtask

    task automatic sweep_b();
        for (int i = 0; i < 8; i++) begin
            dbg_addr_b = 3'(i);
            #1;
            check("reg_b", 32'(dbg_b), 32'(mb[i]));
        end
    endtask

    initial begin
        int          cyc, acc;
        logic        exp_ready, just_acc, acc_ill, vb;
        logic [31:0] held, acc_ins;
        logic [7:0]  be1, be2, bres;
        logic [2:0]  bes;

        for (int i = 0; i < 8; i++) begin
            ma[i] = 8'h00;
            mb[i] = 8'h00;
        end
        rst        = 1'b1;
        instr_a    = '0;
        instr_b    = '0;
        valid_a    = 1'b0;
        valid_b    = 1'b0;
        dbg_addr_a = '0;
        dbg_addr_b = '0;
        #1;
        check("rst_done", 32'(done_a), 32'(0));
        check("rst_error", 32'(err_a), 32'(0));
        check("rst_data1", 32'(d1_a), 32'(0));
        check("rst_data2", 32'(d2_a), 32'(0));
        check("rst_select", 32'(sel_a), 32'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_ready", 32'(ready_a), 32'(1));
        sweep_a();

        // Directed scenarios on the ALU_WAIT=1 instance.
        run_a(mk(8'h00, 3'd1, 3'd0, 8'h05));
        run_a(mk(8'h00, 3'd2, 3'd0, 8'h03));
        run_a(mk(8'h02, 3'd3, 3'd1, 8'h02));
        check("add_r3", 32'(ma[3]), 32'(8'h08));
        run_a(mk(8'h00, 3'd1, 3'd0, 8'h03));
        run_a(mk(8'h00, 3'd2, 3'd0, 8'h05));
        run_a(mk(8'h03, 3'd4, 3'd1, 8'h02));
        run_a(mk(8'h00, 3'd1, 3'd0, 8'hFF));
        run_a(mk(8'h00, 3'd2, 3'd0, 8'h02));
        run_a(mk(8'h02, 3'd3, 3'd1, 8'h02));
        run_a(mk(8'h03, 3'd0, 3'd1, 8'h00));
        run_a(mk(8'h00, 3'd1, 3'd0, 8'hF0));
        run_a(mk(8'h00, 3'd2, 3'd0, 8'h3C));
        run_a(mk(8'h04, 3'd5, 3'd1, 8'h02));
        run_a(mk(8'h05, 3'd6, 3'd1, 8'h02));
        run_a(mk(8'h01, 3'd7, 3'd0, 8'h02));
        run_a(mk(8'h07, 3'd1, 3'd2, 8'h03));
        run_a(mk(8'h02, 3'd2, 3'd2, 8'h02));
        run_a(mk(8'h02, 3'd2, 3'd2, 8'h02));
        sweep_a();

        for (int n = 0; n < 30; n++) begin
            run_a(mk(8'($urandom_range(0, 7)), 3'($urandom), 3'($urandom), 8'($urandom)));
        end
        run_a(mk(8'($urandom_range(6, 255)), 3'($urandom), 3'($urandom), 8'($urandom)));
        sweep_a();

        // Reset in the middle of an instruction.
        instr_a = mk(8'h00, 3'd1, 3'd0, 8'hAA);
        valid_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid_a = 1'b0;
        rst     = 1'b1;
        #1;
        check("abort_data1", 32'(d1_a), 32'(0));
        check("abort_data2", 32'(d2_a), 32'(0));
        check("abort_select", 32'(sel_a), 32'(0));
        for (int i = 0; i < 8; i++) ma[i] = 8'h00;
        for (int i = 0; i < 8; i++) mb[i] = 8'h00;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("abort_done", 32'(done_a), 32'(0));
        end
        sweep_a();
        @(negedge clk);
        rst = 1'b0;
        run_a(mk(8'h00, 3'd2, 3'd0, 8'h11));
        sweep_a();

        // ALU_WAIT=3 instance with INSTR_VALID held high and INSTR changing
        // every cycle; only words present at IDLE edges are executed.
        cyc      = 0;
        acc      = -100;
        just_acc = 1'b0;
        acc_ill  = 1'b0;
        acc_ins  = '0;
        be1 = '0; be2 = '0; bes = '0; bres = '0;
        for (int n = 0; n < 90; n++) begin
            @(negedge clk);
            exp_ready = (cyc >= acc + W_B + 1);
            check("b_ready", 32'(ready_b), 32'(exp_ready));
            check("b_done", 32'(done_b), 32'(cyc == acc + W_B));
            if (cyc == acc + W_B) begin
                check("b_error", 32'(err_b), 32'(acc_ill));
                if (!acc_ill) mb[acc_ins[18:16]] = bres;
            end
            if (just_acc) begin
                check("b_data1", 32'(d1_b), 32'(be1));
                check("b_data2", 32'(d2_b), 32'(be2));
                check("b_select", 32'(sel_b), 32'(bes));
            end
            held    = mk(8'($urandom_range(0, 6)), 3'($urandom), 3'($urandom), 8'($urandom));
            vb      = (n < 80);
            instr_b = held;
            valid_b = vb;
            @(posedge clk);
            cyc++;
            just_acc = exp_ready && vb;
            if (just_acc) begin
                acc     = cyc;
                acc_ins = held;
                ref_op(held, mb, be1, be2, bes, bres, acc_ill);
            end
        end
        @(negedge clk);
        sweep_b();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
